seq_monitor: RTL and testbench
==============================

SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 Parameter BITS_COUNT, default 4, width of monitored count; only value 4 supported.
REQ-002 Parameter LOCK_N, default 4, consecutive legal transitions needed to lock (range 1..15).
REQ-003 Parameter WRAP_W, default 8, width of wrap_count.
REQ-004 Parameter ERR_W, default 4, width of err_count.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  count_in sampled this cycle.
REQ-008 count_in  input  BITS_COUNT  value from upstream one-hot sequence counter (1->2->4->8->1).
REQ-009 clr_err  input  1  clears err_sticky and err_code.
REQ-010 locked  output  1  monitor is in LOCKED state.
REQ-011 expected  output  BITS_COUNT  successor of last accepted legal sample; 0 if none.
REQ-012 err_pulse  output  1  one-cycle error strobe.
REQ-013 err_sticky  output  1  error seen since reset/clr_err.
REQ-014 err_code  output  2  00 none, 01 illegal value, 10 wrong transition; holds first error since clear.
REQ-015 wrap_pulse  output  1  one-cycle strobe on accepted 8->1 in LOCKED.
REQ-016 wrap_count  output  WRAP_W  accepted wraps (stats build only).
REQ-017 err_count  output  ERR_W  errors flagged (stats build only).

Function
REQ-018 Legal values SHALL be 1, 2, 4, 8; successor map 1->2, 2->4, 4->8, 8->1; any other value (incl. 0, repeat of same value) is non-legal as a transition.
REQ-019 FSM states SHALL be SEARCH and LOCKED; only in_valid=1 cycles advance; in_valid=0 holds all state, strobes 0.
REQ-020 SEARCH: legal sample equal to expected increments good counter; legal sample not equal to expected sets good counter to 0 and becomes new reference; illegal sample clears good counter and sets expected to 0; no error flagged in SEARCH.
REQ-021 SEARCH->LOCKED SHALL occur on the edge where good counter reaches LOCK_N; locked=1 the following cycle.
REQ-022 LOCKED: sample==expected -> expected updated to successor, no error.
REQ-023 LOCKED: non-one-hot sample -> err_pulse, err code 01, expected=0, go to SEARCH, good counter 0.
REQ-024 LOCKED: legal sample != expected -> err_pulse, err code 10, sample becomes reference, go to SEARCH, good counter 0.
REQ-025 All outputs SHALL be registered; error/wrap strobes assert the cycle after the offending sample edge (latency 1).
REQ-026 err_code SHALL latch only when err_sticky is 0 (first error wins).
REQ-027 clr_err and a new error in same cycle: error wins; err_sticky stays 1, err_code takes new code.
REQ-028 wrap_pulse SHALL assert only for 8->1 accepted in LOCKED, never on the lock-entry transition's error path.

Reset
REQ-029 reset=1 on a clock edge SHALL force state SEARCH, good counter 0, expected 0, locked 0, all strobes 0, err_sticky 0, err_code 00, wrap_count 0, err_count 0.
REQ-030 Reset SHALL take priority over in_valid and clr_err, including mid-lock.

Configuration
REQ-031 Macro SEQ_MONITOR_STATS_EN defined: wrap_count increments modulo 2^WRAP_W on each wrap_pulse; err_count increments on each err_pulse, saturating at 2^ERR_W-1; clr_err does not clear counters.
REQ-032 Macro undefined: wrap_count and err_count tied to 0, counter registers absent; all other behaviour identical.

Verification
REQ-033 reset, then valid stream 1,2,4,8,1 -> locked=1 one cycle after the 5th sample (4 transitions), err_sticky=0.
REQ-034 locked, stream 2,4,8,1 -> wrap_pulse once after the 1; wrap_count=1 (stats) / 0 (no stats).
REQ-035 locked expecting 4, sample 3 -> err_pulse, err_code=01, locked=0, expected=0 next cycle.
REQ-036 locked expecting 4, sample 8 -> err_code=10, expected=1, relock after 4 further correct samples 1,2,4,8.
REQ-037 err_sticky=1, clr_err=1 same cycle as new wrong transition -> err_sticky stays 1, err_code=10; stats err_count saturates at 15 after 20 errors.
REQ-038 locked, reset pulsed mid-stream with in_valid=1 -> all outputs 0 next cycle; relock needs LOCK_N fresh transitions.

Source files
------------

// File: rtl/seq_monitor_if.sv
// Bus bundle between an upstream one-hot sequence counter and seq_monitor.
// The master drives the sampled count and the error clear; the slave (the
// monitor) returns lock status, prediction, error and wrap reporting.
interface seq_monitor_if #(
   parameter int BITS_COUNT = 4,
   parameter int WRAP_W     = 8,
   parameter int ERR_W      = 4
);
   logic                  in_valid;
   logic [BITS_COUNT-1:0] count_in;
   logic                  clr_err;
   logic                  locked;
   logic [BITS_COUNT-1:0] expected;
   logic                  err_pulse;
   logic                  err_sticky;
   logic [1:0]            err_code;
   logic                  wrap_pulse;
   logic [WRAP_W-1:0]     wrap_count;
   logic [ERR_W-1:0]      err_count;

   modport master (
      output in_valid, count_in, clr_err,
      input  locked, expected, err_pulse, err_sticky, err_code,
             wrap_pulse, wrap_count, err_count
   );

   modport slave (
      input  in_valid, count_in, clr_err,
      output locked, expected, err_pulse, err_sticky, err_code,
             wrap_pulse, wrap_count, err_count
   );
endinterface

// File: rtl/seq_monitor.sv
// seq_monitor: watches a one-hot 1->2->4->8->1 counter stream, locks after
// LOCK_N consecutive legal transitions, and reports illegal values / wrong
// transitions seen while locked. Optional statistics counters are built when
// the macro SEQ_MONITOR_STATS_EN is defined; otherwise they read as zero.
module seq_monitor #(
   parameter int BITS_COUNT = 4,
   parameter int LOCK_N     = 4,
   parameter int WRAP_W     = 8,
   parameter int ERR_W      = 4
) (
   input  logic          clk,
   input  logic          reset,
   seq_monitor_if.slave  bus
);
   typedef enum logic [0:0] {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] LP_LOCK_N  = 4'(LOCK_N);
   localparam logic [1:0] LP_CODE_NONE    = 2'b00;
   localparam logic [1:0] LP_CODE_ILLEGAL = 2'b01;
   localparam logic [1:0] LP_CODE_WRONG   = 2'b10;

   state_t                r_state, w_state_nxt;
   logic [3:0]            r_good, w_good_nxt;
   logic [BITS_COUNT-1:0] r_expected, w_expected_nxt;
   logic                  r_err_pulse, w_err_nxt;
   logic                  r_wrap_pulse, w_wrap_nxt;
   logic                  r_err_sticky, w_sticky_nxt;
   logic [1:0]            r_err_code, w_code_nxt, w_code_new;

   // One-hot legality of a sampled count value
   function automatic logic f_is_legal(input logic [BITS_COUNT-1:0] v);
      case (v)
         4'd1, 4'd2, 4'd4, 4'd8: f_is_legal = 1'b1;
         default:                f_is_legal = 1'b0;
      endcase
   endfunction

   // Successor in the rotating one-hot sequence; 0 for anything illegal
   function automatic logic [BITS_COUNT-1:0] f_succ(input logic [BITS_COUNT-1:0] v);
      case (v)
         4'd1:    f_succ = 4'd2;
         4'd2:    f_succ = 4'd4;
         4'd4:    f_succ = 4'd8;
         4'd8:    f_succ = 4'd1;
         default: f_succ = 4'd0;
      endcase
   endfunction

   // Register all monitor state and output strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= SEARCH;
         r_good       <= 4'd0;
         r_expected   <= '0;
         r_err_pulse  <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_code   <= LP_CODE_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_good       <= w_good_nxt;
         r_expected   <= w_expected_nxt;
         r_err_pulse  <= w_err_nxt;
         r_wrap_pulse <= w_wrap_nxt;
         r_err_sticky <= w_sticky_nxt;
         r_err_code   <= w_code_nxt;
      end
   end

   // Next-state: lock search, tracking while locked, error classification
   always_comb begin
      w_state_nxt    = r_state;
      w_good_nxt     = r_good;
      w_expected_nxt = r_expected;
      w_err_nxt      = 1'b0;
      w_wrap_nxt     = 1'b0;
      w_code_new     = LP_CODE_NONE;
      if (bus.in_valid) begin
         case (r_state)
            SEARCH: begin
               if (!f_is_legal(bus.count_in)) begin
                  w_good_nxt     = 4'd0;
                  w_expected_nxt = '0;
               end else if (bus.count_in == r_expected) begin
                  w_good_nxt     = r_good + 4'd1;
                  w_expected_nxt = f_succ(bus.count_in);
                  if (w_good_nxt == LP_LOCK_N) begin
                     w_state_nxt = LOCKED;
                  end else begin
                     w_state_nxt = SEARCH;
                  end
               end else begin
                  // A fresh legal value restarts the run from this reference
                  w_good_nxt     = 4'd0;
                  w_expected_nxt = f_succ(bus.count_in);
               end
            end
            LOCKED: begin
               if (!f_is_legal(bus.count_in)) begin
                  w_err_nxt      = 1'b1;
                  w_code_new     = LP_CODE_ILLEGAL;
                  w_expected_nxt = '0;
                  w_good_nxt     = 4'd0;
                  w_state_nxt    = SEARCH;
               end else if (bus.count_in == r_expected) begin
                  w_expected_nxt = f_succ(bus.count_in);
                  // Accepting 1 while locked means the 8->1 wrap just happened
                  w_wrap_nxt     = (bus.count_in == 4'd1);
               end else begin
                  w_err_nxt      = 1'b1;
                  w_code_new     = LP_CODE_WRONG;
                  w_expected_nxt = f_succ(bus.count_in);
                  w_good_nxt     = 4'd0;
                  w_state_nxt    = SEARCH;
               end
            end
            default: begin
               w_state_nxt    = SEARCH;
               w_good_nxt     = 4'd0;
               w_expected_nxt = '0;
            end
         endcase
      end else begin
         w_state_nxt    = r_state;
         w_expected_nxt = r_expected;
      end
   end

   // Sticky flag and first-error code; a new error outranks a same-cycle clear
   always_comb begin
      w_sticky_nxt = r_err_sticky;
      w_code_nxt   = r_err_code;
      if (w_err_nxt) begin
         w_sticky_nxt = 1'b1;
         if (!r_err_sticky || bus.clr_err) begin
            w_code_nxt = w_code_new;
         end else begin
            w_code_nxt = r_err_code;
         end
      end else if (bus.clr_err) begin
         w_sticky_nxt = 1'b0;
         w_code_nxt   = LP_CODE_NONE;
      end else begin
         w_sticky_nxt = r_err_sticky;
         w_code_nxt   = r_err_code;
      end
   end

`ifdef SEQ_MONITOR_STATS_EN
   logic [WRAP_W-1:0] r_wrap_count;
   logic [ERR_W-1:0]  r_err_count;

   // Wrap counter rolls over; error counter saturates; neither sees clr_err
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrap_count <= '0;
         r_err_count  <= '0;
      end else begin
         if (w_wrap_nxt) begin
            r_wrap_count <= r_wrap_count + {{(WRAP_W-1){1'b0}}, 1'b1};
         end
         if (w_err_nxt && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.wrap_count = r_wrap_count;
   assign bus.err_count  = r_err_count;
`else
   assign bus.wrap_count = {WRAP_W{1'b0}};
   assign bus.err_count  = {ERR_W{1'b0}};
`endif

   assign bus.locked     = (r_state == LOCKED);
   assign bus.expected   = r_expected;
   assign bus.err_pulse  = r_err_pulse;
   assign bus.err_sticky = r_err_sticky;
   assign bus.err_code   = r_err_code;
   assign bus.wrap_pulse = r_wrap_pulse;
endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_seq_monitor;
   localparam int BITS_COUNT = 4;
   localparam int LOCK_N     = 4;
   localparam int WRAP_W     = 8;
   localparam int ERR_W      = 4;
`ifdef SEQ_MONITOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   seq_monitor_if #(.BITS_COUNT(BITS_COUNT), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

   seq_monitor #(
      .BITS_COUNT(BITS_COUNT), .LOCK_N(LOCK_N), .WRAP_W(WRAP_W), .ERR_W(ERR_W)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit m_locked;
   int m_exp, m_run, m_code, m_wcnt, m_ecnt;
   bit m_sticky, m_errp, m_wrapp;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_onehot(input int s);
      return (s > 0) && (s < 16) && ((s & (s - 1)) == 0);
   endfunction

   function automatic int next_of(input int s);
      return (s == 8) ? 1 : (s * 2);
   endfunction

   task automatic model_step(input bit rst, input bit v, input int s, input bit clr);
      bit err;
      int code;
      err = 1'b0; code = 0;
      m_errp = 1'b0; m_wrapp = 1'b0;
      if (rst) begin
         m_locked = 1'b0; m_exp = 0; m_run = 0; m_code = 0;
         m_sticky = 1'b0; m_wcnt = 0; m_ecnt = 0;
         return;
      end
      if (v) begin
         if (!is_onehot(s)) begin
            if (m_locked) begin err = 1'b1; code = 1; end
            m_locked = 1'b0; m_run = 0; m_exp = 0;
         end else if (s == m_exp) begin
            if (m_locked) m_wrapp = (s == 1);
            else begin
               m_run++;
               if (m_run == LOCK_N) m_locked = 1'b1;
            end
            m_exp = next_of(s);
         end else begin
            if (m_locked) begin err = 1'b1; code = 2; end
            m_locked = 1'b0; m_run = 0; m_exp = next_of(s);
         end
      end
      m_errp = err;
      if (err) begin
         if (!m_sticky || clr) m_code = code;
         m_sticky = 1'b1;
      end else if (clr) begin
         m_sticky = 1'b0; m_code = 0;
      end
      if (STATS) begin
         if (m_wrapp) m_wcnt = (m_wcnt + 1) % (1 << WRAP_W);
         if (err && m_ecnt < (1 << ERR_W) - 1) m_ecnt++;
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".locked"},     32'(bus.locked),     32'(m_locked));
      check_eq({tag, ".expected"},   32'(bus.expected),   32'(m_exp));
      check_eq({tag, ".err_pulse"},  32'(bus.err_pulse),  32'(m_errp));
      check_eq({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(m_sticky));
      check_eq({tag, ".err_code"},   32'(bus.err_code),   32'(m_code));
      check_eq({tag, ".wrap_pulse"}, 32'(bus.wrap_pulse), 32'(m_wrapp));
      check_eq({tag, ".wrap_count"}, 32'(bus.wrap_count), 32'(m_wcnt));
      check_eq({tag, ".err_count"},  32'(bus.err_count),  32'(m_ecnt));
   endtask

   task automatic cyc(input string tag, input bit rst, input bit v, input int s, input bit clr);
      @(negedge clk);
      reset        = rst;
      bus.in_valid = v;
      bus.count_in = 4'(s);
      bus.clr_err  = clr;
      @(posedge clk);
      model_step(rst, v, s, clr);
      #1;
      compare_all(tag);
   endtask

   task automatic feed(input string tag, input int s);
      cyc(tag, 1'b0, 1'b1, s, 1'b0);
   endtask

   task automatic relock(input string tag);
      feed(tag, 1); feed(tag, 2); feed(tag, 4); feed(tag, 8); feed(tag, 1);
   endtask

   initial begin
      int val;
      bit v, clr, rst;
      bus.in_valid = 1'b0;
      bus.count_in = 4'd0;
      bus.clr_err  = 1'b0;

      // Reset state
      cyc("reset", 1'b1, 1'b0, 0, 1'b0);
      cyc("reset", 1'b1, 1'b1, 1, 1'b1);
      check_eq("reset_locked", 32'(bus.locked), 32'd0);
      check_eq("reset_expected", 32'(bus.expected), 32'd0);

      // Lock after 1,2,4,8,1
      feed("lock", 1); feed("lock", 2); feed("lock", 4); feed("lock", 8);
      check_eq("lock_not_yet", 32'(bus.locked), 32'd0);
      feed("lock", 1);
      check_eq("lock_after_5", 32'(bus.locked), 32'd1);
      check_eq("lock_no_err", 32'(bus.err_sticky), 32'd0);

      // Idle cycles hold state
      cyc("idle", 1'b0, 1'b0, 5, 1'b0);
      check_eq("idle_hold_locked", 32'(bus.locked), 32'd1);

      // Wrap on 2,4,8,1
      feed("wrap", 2); feed("wrap", 4); feed("wrap", 8);
      check_eq("wrap_not_yet", 32'(bus.wrap_pulse), 32'd0);
      feed("wrap", 1);
      check_eq("wrap_pulse", 32'(bus.wrap_pulse), 32'd1);
      check_eq("wrap_count", 32'(bus.wrap_count), STATS ? 32'd1 : 32'd0);

      // Illegal value while expecting 4
      feed("ill", 2);
      feed("ill", 3);
      check_eq("ill_pulse", 32'(bus.err_pulse), 32'd1);
      check_eq("ill_code", 32'(bus.err_code), 32'd1);
      check_eq("ill_locked", 32'(bus.locked), 32'd0);
      check_eq("ill_expected", 32'(bus.expected), 32'd0);

      // Wrong transition while expecting 4, then relock from new reference
      cyc("clr", 1'b0, 1'b0, 0, 1'b1);
      check_eq("clr_sticky", 32'(bus.err_sticky), 32'd0);
      relock("wrong"); feed("wrong", 2);
      feed("wrong", 8);
      check_eq("wrong_code", 32'(bus.err_code), 32'd2);
      check_eq("wrong_expected", 32'(bus.expected), 32'd1);
      feed("wrong", 1); feed("wrong", 2); feed("wrong", 4); feed("wrong", 8);
      check_eq("wrong_relock", 32'(bus.locked), 32'd1);

      // New error beats same-cycle clear; first error otherwise wins
      cyc("clrerr", 1'b0, 1'b1, 0, 1'b1);
      check_eq("clrerr_sticky", 32'(bus.err_sticky), 32'd1);
      check_eq("clrerr_code01", 32'(bus.err_code), 32'd1);
      relock("first"); feed("first", 4);
      check_eq("first_wins", 32'(bus.err_code), 32'd1);
      relock("clrerr2"); cyc("clrerr2", 1'b0, 1'b1, 8, 1'b1);
      check_eq("clrerr_code10", 32'(bus.err_code), 32'd2);
      check_eq("clrerr2_sticky", 32'(bus.err_sticky), 32'd1);

      // Error counter saturation
      cyc("sat", 1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         relock("sat"); feed("sat", 4);
      end
      check_eq("err_count_sat", 32'(bus.err_count), STATS ? 32'd15 : 32'd0);

      // Reset mid-lock with in_valid high
      relock("rst"); feed("rst", 2);
      cyc("rst", 1'b1, 1'b1, 4, 1'b0);
      check_eq("rst_locked", 32'(bus.locked), 32'd0);
      check_eq("rst_expected", 32'(bus.expected), 32'd0);
      check_eq("rst_sticky", 32'(bus.err_sticky), 32'd0);
      feed("rst", 1); feed("rst", 2); feed("rst", 4); feed("rst", 8);
      check_eq("rst_relock_early", 32'(bus.locked), 32'd0);
      feed("rst", 1);
      check_eq("rst_relock", 32'(bus.locked), 32'd1);

      // Randomized stream biased towards legal sequences
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) < 7) begin
            val = (m_exp == 0) ? (1 << $urandom_range(3)) : m_exp;
         end else begin
            val = int'($urandom_range(15));
         end
         v   = ($urandom_range(4) != 0);
         clr = ($urandom_range(24) == 0);
         rst = ($urandom_range(299) == 0);
         cyc("rand", rst, v, val, clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
